// File: rtl/countdown_timer.sv
// BCD microwave countdown timer: keypad entry, start/pause/clear, done pulse at 0:00.
// Optional internal 1 s prescaler enabled by defining COUNTDOWN_PRESCALER_EN.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] min_reg, min_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic       running_reg, running_next;
  logic       done_reg, done_next;

  logic       dec_en;
  logic       is_zero;
  logic       dec_to_zero;
  logic       digit_ok;
  logic [3:0] dec_min, dec_tens, dec_ones;

  assign is_zero     = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);
  assign dec_to_zero = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd1);
  assign digit_ok    = digit_valid && (digit <= 4'd9);

`ifdef COUNTDOWN_PRESCALER_EN
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] pre_reg, pre_next;
  logic          pre_wrap;
  logic          unused_tick;

  assign unused_tick = tick;
  assign pre_wrap    = (pre_reg == CW'(TICK_DIV - 1));
  assign dec_en      = (state_reg == RUN) && pre_wrap;

  // Restarting on every entry into RUN makes the first decrement land TICK_DIV cycles after start.
  always_comb begin
    pre_next = pre_reg;
    if (state_reg == RUN) begin
      pre_next = pre_wrap ? '0 : pre_reg + 1'b1;
    end
    if (clear || ((state_next == RUN) && (state_reg != RUN))) begin
      pre_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end
`else
  logic [31:0] unused_div;

  assign unused_div = 32'(TICK_DIV);
  assign dec_en     = tick;
`endif

  // Digitwise borrow; sec_tens values above 5 entered by the operator are counted down as-is.
  always_comb begin
    dec_min  = min_reg;
    dec_tens = tens_reg;
    dec_ones = ones_reg;
    if (ones_reg != 4'd0) begin
      dec_ones = ones_reg - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_reg != 4'd0) begin
        dec_tens = tens_reg - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_reg - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    done_next  = 1'b0;

    if (clear) begin
      state_next = IDLE;
      min_next   = 4'd0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (stop) begin
            state_next = PAUSE;
          end else if (dec_en && !is_zero) begin
            min_next  = dec_min;
            tens_next = dec_tens;
            ones_next = dec_ones;
            if (dec_to_zero) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        IDLE, PAUSE: begin
          if (start && !is_zero) begin
            state_next = RUN;
          end else if ((state_reg == IDLE) && digit_ok) begin
            min_next  = tens_reg;
            tens_next = ones_reg;
            ones_next = digit;
          end
        end
        DONE: begin
          if (digit_ok) begin
            state_next = IDLE;
            min_next   = 4'd0;
            tens_next  = 4'd0;
            ones_next  = digit;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign running_next = (state_next == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      min_reg     <= 4'd0;
      tens_reg    <= 4'd0;
      ones_reg    <= 4'd0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      tens_reg    <= tens_next;
      ones_reg    <= ones_next;
      running_reg <= running_next;
      done_reg    <= done_next;
    end
  end

  assign min      = min_reg;
  assign sec_tens = tens_reg;
  assign sec_ones = ones_reg;
  assign running  = running_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector table plus a modelled full countdown for countdown_timer.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, digit_valid, start, stop, clear;
  logic [3:0] digit;
  logic [3:0] min, sec_tens, sec_ones;
  logic       running, done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .digit       (digit),
    .digit_valid (digit_valid),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .min         (min),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done)
  );

  typedef struct {
    logic       rst, clr, stp, sta, dv;
    logic [3:0] dg;
    logic       tk;
    logic [3:0] m, t, o;
    logic       run, dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, clr, stp, sta, dv, dg, tk, m, t, o, run, dn);
    vec_t v;
    v.rst = rst[0]; v.clr = clr[0]; v.stp = stp[0]; v.sta = sta[0]; v.dv = dv[0];
    v.dg = dg[3:0]; v.tk = tk[0];
    v.m = m[3:0]; v.t = t[3:0]; v.o = o[3:0]; v.run = run[0]; v.dn = dn[0];
    vecs.push_back(v);
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input logic rst, clr, stp, sta, dv, input logic [3:0] dg, input logic tk);
    reset = rst; clear = clr; stop = stp; start = sta; digit_valid = dv; digit = dg; tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] m, t, o, input logic run, dn);
    compared++;
    if ({min, sec_tens, sec_ones, running, done} !== {m, t, o, run, dn}) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0h:%0h%0h run=%b done=%b, required %0h:%0h%0h run=%b done=%b",
               name, idx, min, sec_tens, sec_ones, running, done, m, t, o, run, dn);
    end
  endtask

  initial begin
    int secs;
    int ticks_seen;
    logic tk;

    reset = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0;
    digit_valid = 1'b0; digit = 4'd0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //  rst clr stp sta dv dg tk    m  t  o run dn
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset state
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 3, 0,   0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   1, 3, 0, 0, 0);  // 1:30
    add(0, 0, 0, 0, 0, 0, 1,   1, 3, 0, 0, 0);  // tick in IDLE ignored
    add(0, 0, 1, 0, 0, 0, 0,   1, 3, 0, 0, 0);  // stop in IDLE ignored
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // clear
    add(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // start at 0:00 ignored
    add(0, 0, 0, 0, 1, 10, 0,  0, 0, 0, 0, 0);  // digit A ignored
    add(0, 0, 0, 0, 1, 15, 0,  0, 0, 0, 0, 0);  // digit F ignored
    add(0, 0, 0, 0, 1, 2, 0,   0, 0, 2, 0, 0);  // 0:02
    add(0, 0, 0, 1, 0, 0, 0,   0, 0, 2, 1, 0);  // start
    add(0, 0, 0, 0, 1, 7, 0,   0, 0, 2, 1, 0);  // digit in RUN ignored
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0);  // no tick, no change
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);  // reach 0:00, done pulse
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // done lasts one cycle
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // tick in DONE
    add(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // start in DONE ignored
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0);  // digit from DONE -> 0:01
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0);  // 1:00
    add(0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 5, 9, 1, 0);  // 1:00 -> 0:59
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0);  // 0:10
    add(0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 9, 1, 0);  // 0:10 -> 0:09
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4, 0,   0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 1, 5, 0,   0, 4, 5, 0, 0);  // 0:45
    add(0, 0, 0, 1, 0, 0, 0,   0, 4, 5, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1,   0, 4, 5, 0, 0);  // stop+tick: pause, tick dropped
    add(0, 0, 0, 0, 0, 0, 1,   0, 4, 5, 0, 0);  // tick in PAUSE
    add(0, 0, 0, 0, 1, 3, 0,   0, 4, 5, 0, 0);  // digit in PAUSE ignored
    add(0, 0, 0, 1, 0, 0, 0,   0, 4, 5, 1, 0);  // resume
    add(0, 0, 0, 0, 0, 0, 1,   0, 4, 4, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3, 0,   0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 3, 0, 0, 0);  // 0:30
    add(0, 0, 0, 1, 0, 0, 0,   0, 3, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // clear beats start
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 7, 0,   0, 1, 7, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   1, 7, 0, 0, 0);  // 1:70 entered unnormalized
    add(0, 0, 0, 1, 0, 0, 0,   1, 7, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 6, 9, 1, 0);  // digitwise borrow
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 2, 0,   0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,   0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // reset mid-RUN with tick
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // no done, still idle
    add(0, 0, 0, 0, 1, 8, 0,   0, 0, 8, 0, 0);  // keypad works after reset
    add(0, 0, 0, 0, 1, 9, 0,   0, 8, 9, 0, 0);
    add(0, 0, 0, 0, 1, 9, 0,   8, 9, 9, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   9, 9, 1, 0, 0);  // old min discarded
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].stp, vecs[i].sta, vecs[i].dv, vecs[i].dg, vecs[i].tk);
      check("vec", i, vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].run, vecs[i].dn);
    end

    // Full 2:05 countdown with ticks every other cycle, checked against a seconds model.
    step(0, 0, 0, 0, 1, 4'd2, 0);
    step(0, 0, 0, 0, 1, 4'd0, 0);
    step(0, 0, 0, 0, 1, 4'd5, 0);
    check("load205", 0, 4'd2, 4'd0, 4'd5, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0, 4'd0, 0);
    check("start205", 0, 4'd2, 4'd0, 4'd5, 1'b1, 1'b0);
    secs = 125;
    ticks_seen = 0;
    for (int i = 0; i < 400 && secs > 0; i++) begin
      tk = (i % 2 == 0);
      step(0, 0, 0, 0, 0, 4'd0, tk);
      if (tk) begin
        secs--;
        ticks_seen++;
      end
      check("count", ticks_seen, 4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10),
            secs != 0, tk && (secs == 0));
    end
    compared++;
    if (secs != 0) begin
      mismatched++;
      $display("FAIL countdown_bound: remaining %0d s, required 0", secs);
    end
    step(0, 0, 0, 0, 0, 4'd0, 1);
    check("after_done", 0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
